// File: rtl/op_accum_tree.sv
// ============================================================================
// Module   : op_accum_tree
// Purpose  : Registered binary32 adder tree + multi-beat accumulator with bias
//            and optional ReLU (enable with macro OP_ACC_RELU_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module op_accum_tree #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    NUM_IN     = 3,
   parameter int                    NUM_PASS   = 1,
   parameter logic [DATA_WIDTH-1:0] BIAS       = 32'h4000_0000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_IN*DATA_WIDTH-1:0] i_data,
   input  logic                         i_valid,
   input  logic                         i_flush,
   output logic [DATA_WIDTH-1:0]        o_data,
   output logic                         o_valid,
   output logic                         o_busy
);

   localparam int TREE_LAT = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int LEAVES   = 1 << TREE_LAT;
   localparam int CNT_W    = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_PASS - 1);

   function automatic int lanes_at(input int s);
      return (NUM_IN + (1 << s) - 1) >> s;
   endfunction

   // Combinational binary32 adder (Add_Sub, op=0): RNE rounding, denormals flushed to zero.
   function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] a, b;
      logic [7:0]  ea, eb, d;
      logic [26:0] ma, mb, mb_sh, mask;
      logic [27:0] m;
      logic [24:0] rnd;
      logic        inc;
      int          e, lz;
      if (x[30:0] >= y[30:0]) begin a = x; b = y; end
      else                    begin a = y; b = x; end
      ea = a[30:23];
      eb = b[30:23];
      if (ea == 8'd0) return 32'h0;
      if (ea == 8'hFF || eb == 8'd0) return a;
      ma = {1'b1, a[22:0], 3'b000};
      mb = {1'b1, b[22:0], 3'b000};
      d  = ea - eb;
      if (d > 8'd26) begin
         mb_sh = 27'd1;
      end else begin
         mask      = (27'd1 << d) - 27'd1;
         mb_sh     = mb >> d;
         mb_sh[0]  = mb_sh[0] | (|(mb & mask));
      end
      e = int'(ea);
      if (a[31] == b[31]) begin
         m = {1'b0, ma} + {1'b0, mb_sh};
         if (m[27]) begin
            m = {1'b0, m[27:2], m[1] | m[0]};
            e = e + 1;
         end
      end else begin
         m = {1'b0, ma} - {1'b0, mb_sh};
         if (m == 28'd0) return 32'h0;
         lz = 0;
         for (int i = 0; i < 27; i++) if (m[i]) lz = 26 - i;
         m = m << lz;
         e = e - lz;
         if (e <= 0) return {a[31], 31'h0};
      end
      inc = m[2] & (m[1] | m[0] | m[3]);
      rnd = {1'b0, m[26:3]} + {24'd0, inc};
      if (rnd[24]) begin
         rnd = rnd >> 1;
         e   = e + 1;
      end
      if (e >= 255) return {a[31], 8'hFF, 23'h0};
      return {a[31], 8'(e), rnd[22:0]};
   endfunction

   function automatic logic [DATA_WIDTH-1:0] post(input logic [DATA_WIDTH-1:0] x);
`ifdef OP_ACC_RELU_EN
      return x[DATA_WIDTH-1] ? '0 : x;
`else
      return x;
`endif
   endfunction

   logic [LEAVES-1:0][DATA_WIDTH-1:0]              leaf;
   logic [TREE_LAT:1][LEAVES-1:0][DATA_WIDTH-1:0] stg;
   logic [TREE_LAT:1]                              tvalid;

   genvar k, s;
   generate
      for (k = 0; k < LEAVES; k++) begin : g_leaf
         if (k < NUM_IN) begin : g_in
            assign leaf[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
         end else begin : g_pad
            assign leaf[k] = '0;
         end
      end

      for (s = 1; s <= TREE_LAT; s++) begin : g_stage
         localparam int N_PREV = lanes_at(s - 1);
         logic [LEAVES-1:0][DATA_WIDTH-1:0] src;
         logic [LEAVES-1:0][DATA_WIDTH-1:0] nxt;
         logic                              src_valid;

         if (s == 1) begin : g_src_leaf
            assign src       = leaf;
            assign src_valid = i_valid;
         end else begin : g_src_stg
            assign src       = stg[s-1];
            assign src_valid = tvalid[s-1];
         end

         // Pairs are summed; an odd trailing element passes through unchanged.
         always_comb begin
            nxt = '0;
            for (int j = 0; j < LEAVES / 2; j++) begin
               if (2 * j + 1 < N_PREV)  nxt[j] = fp_add(src[2*j], src[2*j+1]);
               else if (2 * j < N_PREV) nxt[j] = src[2*j];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               stg[s]    <= '0;
               tvalid[s] <= 1'b0;
            end else begin
               tvalid[s] <= src_valid & ~i_flush;
               if (src_valid) stg[s] <= nxt;
            end
         end
      end
   endgenerate

   logic [DATA_WIDTH-1:0] acc;
   logic [CNT_W-1:0]      beat_cnt;
   logic [DATA_WIDTH-1:0] sum;
   logic                  tv;

   assign tv  = tvalid[TREE_LAT];
   assign sum = fp_add((beat_cnt == '0) ? BIAS : acc, stg[TREE_LAT][0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         beat_cnt <= '0;
         o_data   <= '0;
         o_valid  <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (i_flush) begin
            acc      <= '0;
            beat_cnt <= '0;
         end else if (tv) begin
            if (beat_cnt == LAST_BEAT) begin
               o_data   <= post(sum);
               o_valid  <= 1'b1;
               beat_cnt <= '0;
            end else begin
               acc      <= sum;
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end

   assign o_busy = (|tvalid) | (beat_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_op_accum_tree.sv
// ============================================================================
// Module   : tb_op_accum_tree
// Purpose  : Directed self-checking bench for op_accum_tree (NUM_PASS=1 and 2).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_op_accum_tree;

   localparam logic [31:0] ONE  = 32'h3F80_0000;
   localparam logic [31:0] TWO  = 32'h4000_0000;
   localparam logic [31:0] ZERO = 32'h0000_0000;
   localparam logic [31:0] M8   = 32'hC100_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [95:0] d1_data, d2_data;
   logic        d1_valid, d2_valid, d1_flush, d2_flush;
   logic [31:0] q1_data, q2_data;
   logic        q1_valid, q2_valid, q1_busy, q2_busy;

   int n_checks = 0;
   int n_fail   = 0;
   int n_out2   = 0;
   int n_before;

   always #5 clk = ~clk;

   op_accum_tree #(.DATA_WIDTH(32), .NUM_IN(3), .NUM_PASS(1), .BIAS(32'h4000_0000)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i_data(d1_data), .i_valid(d1_valid), .i_flush(d1_flush),
      .o_data(q1_data), .o_valid(q1_valid), .o_busy(q1_busy)
   );

   op_accum_tree #(.DATA_WIDTH(32), .NUM_IN(3), .NUM_PASS(2), .BIAS(32'h4000_0000)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .i_data(d2_data), .i_valid(d2_valid), .i_flush(d2_flush),
      .o_data(q2_data), .o_valid(q2_valid), .o_busy(q2_busy)
   );

   always @(negedge clk) if (q2_valid) n_out2++;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [95:0] beats [4];
   logic [31:0] exp4  [4];
   logic [31:0] exp_t2;

   initial begin
      rst_n    = 1'b0;
      d1_data  = '0; d2_data  = '0;
      d1_valid = 1'b0; d2_valid = 1'b0;
      d1_flush = 1'b0; d2_flush = 1'b0;
      beats = '{{ONE, ONE, ONE}, {TWO, TWO, TWO}, {ZERO, ZERO, ZERO}, {ZERO, ZERO, ONE}};
      exp4  = '{32'h40A0_0000, 32'h4100_0000, 32'h4000_0000, 32'h4040_0000};
`ifdef OP_ACC_RELU_EN
      exp_t2 = 32'h0000_0000;
`else
      exp_t2 = 32'hC080_0000;
`endif
      tick(); tick();
      check_val("rst_d1_data",  q1_data,  32'h0);
      check_val("rst_d1_valid", {31'd0, q1_valid}, 32'h0);
      check_val("rst_d1_busy",  {31'd0, q1_busy},  32'h0);
      check_val("rst_d2_data",  q2_data,  32'h0);
      check_val("rst_d2_valid", {31'd0, q2_valid}, 32'h0);
      check_val("rst_d2_busy",  {31'd0, q2_busy},  32'h0);
      rst_n = 1'b1;
      tick();

      // T1: single beat of ones plus bias
      d1_data = {ONE, ONE, ONE}; d1_valid = 1'b1;
      tick(); d1_valid = 1'b0;
      tick(); check_val("t1_early_valid", {31'd0, q1_valid}, 32'h0);
      tick(); check_val("t1_valid", {31'd0, q1_valid}, 32'h1);
              check_val("t1_data",  q1_data, 32'h40A0_0000);
      tick(); check_val("t1_pulse_end", {31'd0, q1_valid}, 32'h0);
              check_val("t1_hold", q1_data, 32'h40A0_0000);

      // T2: negative sum through post-processing
      d1_data = {M8, ONE, ONE}; d1_valid = 1'b1;
      tick(); d1_valid = 1'b0;
      tick(); tick();
      check_val("t2_valid", {31'd0, q1_valid}, 32'h1);
      check_val("t2_data",  q1_data, exp_t2);

      // T4: back-to-back beats give consecutive outputs
      for (int c = 0; c < 7; c++) begin
         if (c < 4) begin d1_data = beats[c]; d1_valid = 1'b1; end
         else d1_valid = 1'b0;
         tick();
         if (c >= 2 && c < 6) begin
            check_val($sformatf("t4_valid_%0d", c - 2), {31'd0, q1_valid}, 32'h1);
            check_val($sformatf("t4_data_%0d", c - 2), q1_data, exp4[c-2]);
         end else begin
            check_val($sformatf("t4_idle_%0d", c), {31'd0, q1_valid}, 32'h0);
         end
      end

      // T3: two-beat group with idle gap
      d2_data = {ONE, ONE, ONE}; d2_valid = 1'b1;
      tick(); d2_valid = 1'b0;
      check_val("t3_busy_a", {31'd0, q2_busy}, 32'h1);
      tick();
      tick(); check_val("t3_busy_b", {31'd0, q2_busy}, 32'h1);
              check_val("t3_no_early", {31'd0, q2_valid}, 32'h0);
      d2_valid = 1'b1;
      tick(); d2_valid = 1'b0;
      tick(); check_val("t3_not_yet", {31'd0, q2_valid}, 32'h0);
      tick(); check_val("t3_valid", {31'd0, q2_valid}, 32'h1);
              check_val("t3_data",  q2_data, 32'h4100_0000);
      tick(); check_val("t3_pulse_end", {31'd0, q2_valid}, 32'h0);
              check_val("t3_idle_busy", {31'd0, q2_busy}, 32'h0);

      // T5: flush discards a partial group
      n_before = n_out2;
      d2_data = {ONE, ONE, ONE}; d2_valid = 1'b1;
      tick(); d2_valid = 1'b0;
      tick(); tick();
      d2_flush = 1'b1;
      tick(); d2_flush = 1'b0;
      check_val("t5_flush_busy", {31'd0, q2_busy}, 32'h0);
      d2_data = {ZERO, ZERO, ONE}; d2_valid = 1'b1;
      tick(); tick(); d2_valid = 1'b0;
      tick(); tick();
      check_val("t5_valid", {31'd0, q2_valid}, 32'h1);
      check_val("t5_data",  q2_data, 32'h4080_0000);
      tick(); tick(); tick();
      check_val("t5_out_count", n_out2 - n_before, 32'd1);

      // T6: asynchronous reset mid-group
      d2_data = {ONE, ONE, ONE}; d2_valid = 1'b1;
      tick(); d2_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_val("t6_rst_data",  q2_data, 32'h0);
      check_val("t6_rst_valid", {31'd0, q2_valid}, 32'h0);
      check_val("t6_rst_busy",  {31'd0, q2_busy},  32'h0);
      tick(); rst_n = 1'b1;
      tick();
      d2_valid = 1'b1;
      tick(); tick(); d2_valid = 1'b0;
      tick(); tick();
      check_val("t6_valid", {31'd0, q2_valid}, 32'h1);
      check_val("t6_data",  q2_data, 32'h4100_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
